// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read arbiter sharing one DDR AR/R channel.
// One burst in flight; R beats are steered to the granted port only.
module axi_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk_100Mhz,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              grant,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [8:0] beat_cnt;
    logic       pick;
    logic       win;
    logic       beat;
    logic       in_data;

    always_comb begin
        state_nxt  = state;
        pick       = 1'b0;
        win        = 1'b0;
        beat       = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        m_rready   = 1'b0;
        unique case (state)
            IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    pick      = 1'b1;
                    state_nxt = ADDR;
                    if (s0_arvalid && s1_arvalid)
                        win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
                    else
                        win = s1_arvalid;
                end
            end
            ADDR: begin
                s0_arready = m_arready & ~grant;
                s1_arready = m_arready & grant;
                if (m_arvalid && m_arready)
                    state_nxt = DATA;
            end
            DATA: begin
                m_rready  = grant ? s1_rready : s0_rready;
                s0_rvalid = m_rvalid & ~grant;
                s1_rvalid = m_rvalid & grant;
                beat      = m_rvalid & (grant ? s1_rready : s0_rready);
                if (beat && m_rlast)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arsize   <= '0;
            m_arburst  <= '0;
            m_arvalid  <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_err    <= 1'b0;
        end else begin
            if (pick) begin
                m_araddr  <= win ? s1_araddr : s0_araddr;
                m_arlen   <= win ? s1_arlen : s0_arlen;
                m_arsize  <= win ? s1_arsize : s0_arsize;
                m_arburst <= win ? s1_arburst : s0_arburst;
                m_arvalid <= 1'b1;
                grant     <= win;
                beat_cnt  <= '0;
            end
            if (state == ADDR && m_arready)
                m_arvalid <= 1'b0;
            if (beat) begin
                // Saturate so a runaway DDR burst cannot alias a short one
                if (beat_cnt != 9'h1FF)
                    beat_cnt <= beat_cnt + 9'd1;
                if (m_rlast) begin
                    last_grant <= grant;
                    if (beat_cnt != {1'b0, m_arlen})
                        len_err <= 1'b1;
                end else if (beat_cnt == {1'b0, m_arlen}) begin
                    len_err <= 1'b1;
                end
            end
        end
    end

    assign in_data  = (state == DATA);
    assign busy     = (state != IDLE);
    assign s0_rdata = in_data ? m_rdata : '0;
    assign s1_rdata = in_data ? m_rdata : '0;
    assign s0_rresp = in_data ? m_rresp : 2'b00;
    assign s1_rresp = in_data ? m_rresp : 2'b00;
    assign s0_rlast = in_data & m_rlast;
    assign s1_rlast = in_data & m_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed bursts, queued
// AR/R expectations checked by an independent negedge monitor.
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic          last;
    } rexp_t;

    typedef struct packed {
        logic          port;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } arexp_t;

    logic clk_100Mhz = 1'b0;
    always #5 clk_100Mhz = ~clk_100Mhz;

    logic          rst_n;
    logic [AW-1:0] s0_araddr, s1_araddr;
    logic [7:0]    s0_arlen, s1_arlen;
    logic [2:0]    s0_arsize, s1_arsize;
    logic [1:0]    s0_arburst, s1_arburst;
    logic          s0_arvalid, s1_arvalid;
    logic          s0_rready, s1_rready;
    logic          rdy0, tog, tog_en;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast, m_rvalid;

    logic          s0_arready, s1_arready;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic [1:0]    s0_rresp, s1_rresp;
    logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid, m_rready, grant, busy, len_err;

    logic          f_s0_arready, f_s1_arready;
    logic [DW-1:0] f_s0_rdata, f_s1_rdata;
    logic [1:0]    f_s0_rresp, f_s1_rresp;
    logic          f_s0_rlast, f_s1_rlast, f_s0_rvalid, f_s1_rvalid;
    logic [AW-1:0] f_m_araddr;
    logic [7:0]    f_m_arlen;
    logic [2:0]    f_m_arsize;
    logic [1:0]    f_m_arburst;
    logic          f_m_arvalid, f_m_rready, f_grant, f_busy, f_len_err;

    assign s0_rready = tog_en ? tog : rdy0;

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk_100Mhz(clk_100Mhz), .rst_n(rst_n),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clk_100Mhz(clk_100Mhz), .rst_n(rst_n),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_arvalid(s0_arvalid), .s0_arready(f_s0_arready),
        .s0_rdata(f_s0_rdata), .s0_rresp(f_s0_rresp),
        .s0_rlast(f_s0_rlast), .s0_rvalid(f_s0_rvalid),
        .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
        .s1_arvalid(s1_arvalid), .s1_arready(f_s1_arready),
        .s1_rdata(f_s1_rdata), .s1_rresp(f_s1_rresp),
        .s1_rlast(f_s1_rlast), .s1_rvalid(f_s1_rvalid),
        .s1_rready(s1_rready),
        .m_araddr(f_m_araddr), .m_arlen(f_m_arlen),
        .m_arsize(f_m_arsize), .m_arburst(f_m_arburst),
        .m_arvalid(f_m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(f_m_rready),
        .grant(f_grant), .busy(f_busy), .len_err(f_len_err)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    int     rcv_cnt = 0;
    rexp_t  rq[$];
    arexp_t aq[$];
    rexp_t  re;
    arexp_t ae;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        tog = 1'b1;
        forever begin
            @(posedge clk_100Mhz);
            #1 tog = ~tog;
        end
    end

    // Monitor: pops the scoreboard on every observed handshake
    initial begin
        forever begin
            @(negedge clk_100Mhz);
            if (rst_n) begin
                if (s0_rvalid && s1_rvalid) chk("rvalid_both", 1, 0);
                if (m_arvalid && m_arready) begin
                    if (aq.size() == 0) chk("ar_unexpected", 1, 0);
                    else begin
                        ae = aq.pop_front();
                        chk("ar_grant", grant, ae.port);
                        chk("ar_addr", m_araddr, ae.addr);
                        chk("ar_len", m_arlen, ae.len);
                        chk("s_arready", {s1_arready, s0_arready},
                            ae.port ? 2'b10 : 2'b01);
                    end
                end
                if (busy && !m_arvalid)
                    chk("m_rready_mirror", m_rready,
                        grant ? s1_rready : s0_rready);
                if ((s0_rvalid && s0_rready) || (s1_rvalid && s1_rready)) begin
                    rcv_cnt++;
                    if (rq.size() == 0) chk("r_unexpected", 1, 0);
                    else begin
                        re = rq.pop_front();
                        chk("r_port", s1_rvalid, re.port);
                        chk("r_data", s1_rvalid ? s1_rdata : s0_rdata, re.data);
                        chk("r_last", s1_rvalid ? s1_rlast : s0_rlast, re.last);
                    end
                end
            end
        end
    end

    task automatic ar_phase(input int dly, input logic port,
                            input logic [AW-1:0] addr, input logic [7:0] len,
                            input bit drop);
        int n;
        aq.push_back('{port: port, addr: addr, len: len});
        n = 0;
        @(negedge clk_100Mhz);
        chk("idle_busy", busy, 0);
        chk("idle_arvalid", m_arvalid, 0);
        while (!m_arvalid && n < 20) begin
            @(negedge clk_100Mhz);
            n++;
        end
        chk("ar_latency", n, 1);
        if (!m_arvalid) return;
        chk("fp_grant", f_grant, 0);
        chk("fp_araddr", f_m_araddr, s0_araddr);
        for (int i = 0; i < dly; i++) begin
            chk("arready_wait", {s1_arready, s0_arready}, 2'b00);
            @(negedge clk_100Mhz);
        end
        @(posedge clk_100Mhz);
        #1 m_arready = 1'b1;
        @(posedge clk_100Mhz);
        #1 m_arready = 1'b0;
        if (drop) begin
            s0_arvalid = 1'b0;
            s1_arvalid = 1'b0;
        end
    endtask

    task automatic r_phase(input logic port, input int n, input int last_idx,
                           input logic [DW-1:0] base);
        int w;
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + DW'(i);
            m_rresp  = 2'b00;
            m_rlast  = (i == last_idx);
            rq.push_back('{port: port, data: base + DW'(i), last: (i == last_idx)});
            w = 0;
            @(negedge clk_100Mhz);
            while (!m_rready && w < 100) begin
                @(negedge clk_100Mhz);
                w++;
            end
            if (!m_rready) begin
                chk("r_timeout", 0, 1);
                break;
            end
            @(posedge clk_100Mhz);
            #1;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        s0_araddr = 32'h1000; s1_araddr = 32'h2000;
        s0_arlen = 8'd3; s1_arlen = 8'd3;
        s0_arsize = 3'd3; s1_arsize = 3'd3;
        s0_arburst = 2'd1; s1_arburst = 2'd1;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        rdy0 = 1'b1; s1_rready = 1'b1; tog_en = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rvalid = 1'b0;
        repeat (2) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_arready", {s1_arready, s0_arready}, 0);
        @(posedge clk_100Mhz);
        #1 rst_n = 1'b1;

        // Round robin: both request continuously, expect 0,1,0,1
        s0_arvalid = 1'b1;
        s1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ar_phase(1, k[0], k[0] ? 32'h2000 : 32'h1000, 8'd3, k == 3);
            r_phase(k[0], 4, 3, 64'h100 * (k + 1));
        end

        // Single port 0 burst with delayed DDR arready
        s0_araddr = 32'h1000;
        s0_arlen  = 8'd63;
        s0_arvalid = 1'b1;
        c0 = rcv_cnt;
        ar_phase(3, 1'b0, 32'h1000, 8'd63, 1'b1);
        r_phase(1'b0, 64, 63, 64'hA000);
        chk("t1_beats", rcv_cnt - c0, 64);

        // rready toggling during a 64-beat burst
        s0_araddr = 32'h3000;
        s0_arvalid = 1'b1;
        c0 = rcv_cnt;
        ar_phase(0, 1'b0, 32'h3000, 8'd63, 1'b1);
        tog_en = 1'b1;
        r_phase(1'b0, 64, 63, 64'hB000);
        tog_en = 1'b0;
        chk("tog_beats", rcv_cnt - c0, 64);
        chk("len_err_clean", len_err, 0);

        // Early rlast, then sticky len_err across a good burst
        s0_araddr = 32'h4000;
        s0_arvalid = 1'b1;
        ar_phase(0, 1'b0, 32'h4000, 8'd63, 1'b1);
        r_phase(1'b0, 32, 31, 64'hC000);
        s0_arlen = 8'd3;
        s0_arvalid = 1'b1;
        ar_phase(0, 1'b0, 32'h4000, 8'd3, 1'b1);
        chk("len_err_set", len_err, 1);
        r_phase(1'b0, 4, 3, 64'hC100);
        chk("len_err_sticky", len_err, 1);

        // Reset during beat 20 of a port 0 burst
        s0_arlen = 8'd63;
        s0_arvalid = 1'b1;
        ar_phase(0, 1'b0, 32'h4000, 8'd63, 1'b1);
        r_phase(1'b0, 20, -1, 64'hD000);
        m_rvalid = 1'b1;
        m_rdata  = 64'hD014;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_arvalid", m_arvalid, 0);
        chk("mid_rst_m_rready", m_rready, 0);
        chk("mid_rst_rvalid", {s1_rvalid, s0_rvalid}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_len_err", len_err, 0);
        chk("mid_rst_m_araddr", m_araddr, 0);
        chk("mid_rst_m_arlen", m_arlen, 0);
        m_rvalid = 1'b0;
        @(posedge clk_100Mhz);
        #1 rst_n = 1'b1;
        s0_araddr = 32'h5000; s1_araddr = 32'h6000;
        s0_arlen = 8'd3;
        s0_arvalid = 1'b1;
        s1_arvalid = 1'b1;
        ar_phase(0, 1'b0, 32'h5000, 8'd3, 1'b1);
        r_phase(1'b0, 4, 3, 64'hE000);

        repeat (2) @(posedge clk_100Mhz);
        chk("rq_empty", rq.size(), 0);
        chk("aq_empty", aq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
